// File: rtl/vme_csr_pkg.sv
// Shared constants, ADER layout and AM helpers for the
// VME64x CR/CSR responder.
package vme_csr_pkg;

  localparam logic [18:0] c_ADER_BASE   = 19'h7FF63;
  localparam logic [18:0] c_ADER_STRIDE = 19'h00010;
  localparam logic [18:0] c_BIT_SET     = 19'h7FFFB;
  localparam logic [18:0] c_BIT_CLR     = 19'h7FFF7;
  localparam logic [18:0] c_USR_CTRL    = 19'h7FF33;

  localparam logic [5:0]  c_AM_CSR      = 6'h2F;
  localparam logic [31:0] c_ADER_RST    = 32'h0000_0001;

  typedef struct packed {
    logic [23:0] base;
    logic [5:0]  am;
    logic        rsv;
    logic        dis;
  } t_ader;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CSR,
    S_DEC,
    S_ACK
  } t_state;

  function automatic logic is_a24_am(input logic [5:0] am);
    return am[5:3] == 3'b111;
  endfunction

  function automatic logic is_a32_am(input logic [5:0] am);
    return am[5:3] == 3'b001;
  endfunction

endpackage

// File: rtl/vme_func_match.sv
// Compares one active ADER against the current access and
// yields a hit flag plus the in-window offset.
module vme_func_match
  import vme_csr_pkg::*;
#(
  parameter int g_win24_bits = 19,
  parameter int g_win32_bits = 24
) (
  input  t_ader       ader,
  input  logic [31:0] addr,
  input  logic [5:0]  am,
  input  logic        enable,
  output logic        hit,
  output logic [31:0] offset
);

  localparam logic [31:0] c_mask24 =
    (32'd1 << g_win24_bits) - 32'd1;
  localparam logic [31:0] c_mask32 =
    (32'd1 << g_win32_bits) - 32'd1;

  logic [31:0] diff;
  logic        a24;
  logic        a32;
  logic        m24;
  logic        m32;
  logic        unused_rsv;

  assign unused_rsv = ader.rsv;

  // Window compare: only bits above the window size matter
  always_comb begin
    diff   = addr ^ {ader.base, 8'h00};
    a24    = is_a24_am(am);
    a32    = is_a32_am(am);
    m24    = (diff[23:0] >> g_win24_bits) == 24'd0;
    m32    = (diff >> g_win32_bits) == 32'd0;
    hit    = enable && !ader.dis && (am == ader.am) &&
             ((a24 && m24) || (a32 && m32));
    offset = '0;
    if (hit)
      offset = addr & (a24 ? c_mask24 : c_mask32);
  end

endmodule

// File: rtl/vme_csr_ader_responder.sv
// VME64x CR/CSR responder: ADER/BIT_SET/BIT_CLR/USR_CTRL
// registers plus A24/A32 function decode.
module vme_csr_ader_responder
  import vme_csr_pkg::*;
#(
  parameter int g_num_func   = 8,
  parameter int g_win24_bits = 19,
  parameter int g_win32_bits = 24
) (
  input  logic        clk_sys_i,
  input  logic        rst_n_i,
  input  logic        acc_valid_i,
  input  logic [31:0] acc_addr_i,
  input  logic [5:0]  acc_am_i,
  input  logic        acc_we_i,
  input  logic [7:0]  acc_data_i,
  output logic        acc_ack_o,
  output logic [7:0]  acc_rdata_o,
  output logic        dec_valid_o,
  output logic        dec_hit_o,
  output logic [2:0]  dec_func_o,
  output logic [31:0] dec_offset_o,
  output logic        module_enable_o,
  output logic [7:0]  usr_ctrl_o,
  output logic        soft_rst_o
);

  localparam logic [3:0] c_nf = 4'(g_num_func);

  t_state      state;
  logic [31:0] shadow [8];
  logic [31:0] active [8];
  logic        enable;
  logic [7:0]  usr;

  logic [18:0] off;
  logic [18:0] diff;
  logic [2:0]  ader_f;
  logic [1:0]  ader_b;
  logic        ader_ok;
  logic [31:0] ader_cur;
  logic [31:0] ader_new;
  logic [7:0]  ader_byte;
  logic [7:0]  csr_rdata;
  logic        csr_wr;

  logic [g_num_func-1:0] hits;
  logic [31:0]           offs [g_num_func];
  logic                  hit_any;
  logic [2:0]            hit_func;
  logic [31:0]           hit_off;

  assign module_enable_o = enable;
  assign usr_ctrl_o      = usr;
  assign csr_wr          = (state == S_CSR) && acc_we_i;

  // CSR address decode, read mux and ADER byte merge
  always_comb begin
    off       = acc_addr_i[18:0];
    diff      = off - c_ADER_BASE;
    ader_f    = 3'(diff / c_ADER_STRIDE);
    ader_b    = diff[3:2];
    ader_ok   = (diff < 19'h80) && (diff[1:0] == 2'b00) &&
                ({1'b0, ader_f} < c_nf);
    ader_cur  = shadow[ader_f];
    ader_new  = ader_cur;
    ader_byte = 8'h00;
    case (ader_b)
      2'd0: begin
        ader_byte       = ader_cur[31:24];
        ader_new[31:24] = acc_data_i;
      end
      2'd1: begin
        ader_byte       = ader_cur[23:16];
        ader_new[23:16] = acc_data_i;
      end
      2'd2: begin
        ader_byte       = ader_cur[15:8];
        ader_new[15:8]  = acc_data_i;
      end
      default: begin
        ader_byte       = ader_cur[7:0];
        ader_new[7:0]   = acc_data_i;
      end
    endcase
    csr_rdata = 8'h00;
    unique case (1'b1)
      ader_ok:
        csr_rdata = ader_byte;
      (off == c_BIT_SET) || (off == c_BIT_CLR):
        csr_rdata = {3'b000, enable, 4'b0000};
      (off == c_USR_CTRL):
        csr_rdata = usr;
      default:
        csr_rdata = 8'h00;
    endcase
  end

  // CSR register file; byte 3 commits shadow to active
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= c_ADER_RST;
        active[i] <= c_ADER_RST;
      end
      enable <= 1'b0;
      usr    <= 8'h00;
    end else if (csr_wr) begin
      if (ader_ok) begin
        shadow[ader_f] <= ader_new;
        if (ader_b == 2'd3)
          active[ader_f] <= ader_new;
      end
      if (off == c_BIT_SET) begin
        if (acc_data_i[4])
          enable <= 1'b1;
        if (acc_data_i[7]) begin
          for (int i = 0; i < 8; i++) begin
            shadow[i] <= c_ADER_RST;
            active[i] <= c_ADER_RST;
          end
          usr <= 8'h00;
        end
      end
      if (off == c_BIT_CLR && acc_data_i[4])
        enable <= 1'b0;
      if (off == c_USR_CTRL)
        usr <= acc_data_i;
    end
  end

  for (genvar i = 0; i < g_num_func; i++) begin : g_match
    vme_func_match #(
      .g_win24_bits (g_win24_bits),
      .g_win32_bits (g_win32_bits)
    ) u_match (
      .ader   (active[i]),
      .addr   (acc_addr_i),
      .am     (acc_am_i),
      .enable (enable),
      .hit    (hits[i]),
      .offset (offs[i])
    );
  end

  // Priority encoder: lowest matching function wins
  always_comb begin
    hit_any  = 1'b0;
    hit_func = 3'd0;
    hit_off  = 32'd0;
    for (int i = g_num_func - 1; i >= 0; i--) begin
      if (hits[i]) begin
        hit_any  = 1'b1;
        hit_func = 3'(i);
        hit_off  = offs[i];
      end
    end
  end

  // Access FSM with registered ack, read data and decode
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= S_IDLE;
      acc_ack_o    <= 1'b0;
      acc_rdata_o  <= 8'h00;
      dec_valid_o  <= 1'b0;
      dec_hit_o    <= 1'b0;
      dec_func_o   <= 3'd0;
      dec_offset_o <= 32'd0;
      soft_rst_o   <= 1'b0;
    end else begin
      acc_ack_o   <= 1'b0;
      dec_valid_o <= 1'b0;
      soft_rst_o  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (acc_valid_i)
            state <= (acc_am_i == c_AM_CSR) ? S_CSR : S_DEC;
        end
        S_CSR: begin
          state       <= S_ACK;
          acc_ack_o   <= 1'b1;
          acc_rdata_o <= csr_rdata;
          soft_rst_o  <= csr_wr && (off == c_BIT_SET) &&
                         acc_data_i[7];
        end
        S_DEC: begin
          state        <= S_ACK;
          acc_ack_o    <= 1'b1;
          dec_valid_o  <= 1'b1;
          dec_hit_o    <= hit_any;
          dec_func_o   <= hit_func;
          dec_offset_o <= hit_off;
        end
        S_ACK: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vme_csr_ader_responder.sv
// Randomized scoreboard bench for vme_csr_ader_responder
// with a behavioural CSR/decode reference model.
module tb_vme_csr_ader_responder;

  localparam int NF = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        acc_valid = 1'b0;
  logic [31:0] acc_addr = '0;
  logic [5:0]  acc_am = '0;
  logic        acc_we = 1'b0;
  logic [7:0]  acc_data = '0;
  logic        acc_ack_o;
  logic [7:0]  acc_rdata_o;
  logic        dec_valid_o;
  logic        dec_hit_o;
  logic [2:0]  dec_func_o;
  logic [31:0] dec_offset_o;
  logic        module_enable_o;
  logic [7:0]  usr_ctrl_o;
  logic        soft_rst_o;

  always #5 clk = ~clk;

  vme_csr_ader_responder dut (
    .clk_sys_i       (clk),
    .rst_n_i         (rst_n),
    .acc_valid_i     (acc_valid),
    .acc_addr_i      (acc_addr),
    .acc_am_i        (acc_am),
    .acc_we_i        (acc_we),
    .acc_data_i      (acc_data),
    .acc_ack_o       (acc_ack_o),
    .acc_rdata_o     (acc_rdata_o),
    .dec_valid_o     (dec_valid_o),
    .dec_hit_o       (dec_hit_o),
    .dec_func_o      (dec_func_o),
    .dec_offset_o    (dec_offset_o),
    .module_enable_o (module_enable_o),
    .usr_ctrl_o      (usr_ctrl_o),
    .soft_rst_o      (soft_rst_o)
  );

  typedef struct {
    bit         is_dec;
    bit         chk_rd;
    logic [7:0] rd;
    logic       hit;
    logic [2:0] func;
    logic [31:0] off;
    logic       en;
    logic [7:0] usr;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int npass = 0;
  int ntot = 0;
  int soft_seen = 0;
  int soft_exp = 0;

  bit [31:0] m_sh [8];
  bit [31:0] m_act [8];
  bit        m_en;
  bit [7:0]  m_usr;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s got %0h want %0h", nm, act, exp);
  endtask

  function automatic void model_clear();
    for (int f = 0; f < 8; f++) begin
      m_sh[f]  = 32'h1;
      m_act[f] = 32'h1;
    end
    m_usr = 8'h00;
  endfunction

  function automatic exp_t model_csr(bit [31:0] a, bit we,
                                     bit [7:0] d);
    exp_t e;
    int   o;
    e = '{default: 0};
    e.chk_rd = !we;
    o = int'(a & 32'h7FFFF);
    for (int f = 0; f < 8; f++)
      for (int b = 0; b < 4; b++)
        if (o == 'h7FF63 + 16 * f + 4 * b && f < NF) begin
          e.rd = m_sh[f][31 - 8 * b -: 8];
          if (we) begin
            m_sh[f][31 - 8 * b -: 8] = d;
            if (b == 3) m_act[f] = m_sh[f];
          end
        end
    if (o == 'h7FFFB || o == 'h7FFF7)
      e.rd = m_en ? 8'h10 : 8'h00;
    if (o == 'h7FFFB && we) begin
      if (d[4]) m_en = 1'b1;
      if (d[7]) begin
        model_clear();
        soft_exp++;
      end
    end
    if (o == 'h7FFF7 && we && d[4]) m_en = 1'b0;
    if (o == 'h7FF33) begin
      e.rd = m_usr;
      if (we) m_usr = d;
    end
    e.en  = m_en;
    e.usr = m_usr;
    return e;
  endfunction

  function automatic exp_t model_dec(bit [31:0] a, bit [5:0] am);
    exp_t e;
    bit   a24, a32, ok;
    e = '{default: 0};
    e.is_dec = 1'b1;
    a24 = (am >= 6'h38);
    a32 = (am >= 6'h08 && am <= 6'h0F);
    for (int f = 0; f < NF; f++) begin
      ok = m_en && (m_act[f][0] == 1'b0) &&
           (am == m_act[f][7:2]);
      if (a24)
        ok = ok && ((a % 32'h100_0000) / 32'h8_0000 ==
                    (m_act[f] % 32'h100_0000) / 32'h8_0000);
      else if (a32)
        ok = ok && (a / 32'h100_0000 ==
                    m_act[f] / 32'h100_0000);
      else
        ok = 1'b0;
      if (ok && !e.hit) begin
        e.hit  = 1'b1;
        e.func = 3'(f);
        e.off  = a24 ? a % 32'h8_0000 : a % 32'h100_0000;
      end
    end
    e.en  = m_en;
    e.usr = m_usr;
    return e;
  endfunction

  task automatic access(input logic [31:0] a,
                        input logic [5:0] am,
                        input bit we, input logic [7:0] d);
    exp_t e;
    int   n;
    bit   got;
    @(negedge clk);
    if (am == 6'h2F) e = model_csr(a, we, d);
    else e = model_dec(a, am);
    q.push_back(e);
    acc_valid = 1'b1;
    acc_addr  = a;
    acc_am    = am;
    acc_we    = we;
    acc_data  = d;
    got = 1'b0;
    n = 0;
    while (!got && n < 8) begin
      @(negedge clk);
      n++;
      if (acc_ack_o) got = 1'b1;
    end
    acc_valid = 1'b0;
    if (got) chk("ack_latency", 64'(n), 64'd2);
    else begin
      ntot++;
      $display("FAIL ack_timeout addr %h got none want ack", a);
      void'(q.pop_back());
    end
    @(negedge clk);
  endtask

  task automatic csr_wr(input logic [18:0] a,
                        input logic [7:0] d);
    access({13'h0, a}, 6'h2F, 1'b1, d);
  endtask

  task automatic csr_rd(input logic [31:0] a);
    access(a, 6'h2F, 1'b0, 8'h00);
  endtask

  task automatic ader_wr(input int f, input logic [31:0] v,
                         input int nb);
    for (int b = 0; b < nb; b++)
      csr_wr(19'('h7FF63 + 16 * f + 4 * b), v[31 - 8 * b -: 8]);
  endtask

  task automatic ader_rd(input int f);
    for (int b = 0; b < 4; b++)
      csr_rd(32'('h7FF63 + 16 * f + 4 * b));
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (soft_rst_o) soft_seen++;
      if (acc_ack_o) begin
        if (q.size() == 0) begin
          ntot++;
          $display("FAIL unexpected_ack got ack want none");
        end else begin
          me = q.pop_front();
          chk("dec_valid", 64'(dec_valid_o), 64'(me.is_dec));
          if (me.is_dec) begin
            chk("dec_hit", 64'(dec_hit_o), 64'(me.hit));
            chk("dec_func", 64'(dec_func_o), 64'(me.func));
            chk("dec_offset", 64'(dec_offset_o), 64'(me.off));
          end else if (me.chk_rd) begin
            chk("rdata", 64'(acc_rdata_o), 64'(me.rd));
          end
          chk("enable", 64'(module_enable_o), 64'(me.en));
          chk("usr_ctrl", 64'(usr_ctrl_o), 64'(me.usr));
        end
      end else if (dec_valid_o) begin
        ntot++;
        $display("FAIL dec_valid_no_ack got 1 want 0");
      end
    end
  end

  localparam logic [5:0] c_ams [7] =
    '{6'h39, 6'h3D, 6'h09, 6'h0D, 6'h3A, 6'h00, 6'h3F};

  initial begin
    logic [31:0] v, a;
    int          f, r, sel;
    logic [5:0]  am;
    m_en = 1'b0;
    model_clear();

    repeat (3) @(negedge clk);
    chk("rst_ack", 64'(acc_ack_o), 64'd0);
    chk("rst_outs_a", {acc_rdata_o, dec_valid_o, dec_hit_o,
                       dec_func_o}, 64'd0);
    chk("rst_offset", 64'(dec_offset_o), 64'd0);
    chk("rst_outs_b", {module_enable_o, usr_ctrl_o,
                       soft_rst_o}, 64'd0);
    rst_n = 1'b1;

    // decode before enable, then program func1
    access(32'hC00000, 6'h39, 1'b0, 8'h00);
    ader_wr(1, 32'h00C000E4, 4);
    csr_wr(19'h7FF33, 8'h01);
    csr_wr(19'h7FFFB, 8'h10);
    access(32'hC00000, 6'h39, 1'b0, 8'h00);
    access(32'hC11000, 6'h39, 1'b0, 8'h00);
    ader_rd(1);

    // func0 left disabled
    ader_wr(0, 32'h00000001, 4);
    access(32'h000100, 6'h00, 1'b0, 8'h00);

    // ADER2 staged in shadow, committed by byte 3
    ader_wr(2, 32'h00D000E4, 3);
    for (int b = 0; b < 3; b++)
      csr_rd(32'('h7FF83 + 4 * b));
    access(32'hD00000, 6'h39, 1'b0, 8'h00);
    csr_wr(19'h7FF8F, 8'hE4);
    access(32'hD00000, 6'h39, 1'b0, 8'h00);

    // A32 function and priority among duplicates
    ader_wr(4, 32'h12000024, 4);
    access(32'h12345678, 6'h09, 1'b0, 8'h00);
    ader_wr(3, 32'h00E000E4, 4);
    ader_wr(5, 32'h00E000E4, 4);
    access(32'hE7FFFF, 6'h39, 1'b0, 8'h00);

    // unmapped read, enable clear/set, register reads
    csr_rd(32'h0007FF00);
    csr_rd(32'hFFF7FF33);
    csr_wr(19'h7FFF7, 8'h10);
    csr_rd(32'h0007FFFB);
    access(32'hC11000, 6'h39, 1'b0, 8'h00);
    csr_wr(19'h7FFFB, 8'h10);
    csr_rd(32'h0007FFF7);

    // soft reset
    csr_wr(19'h7FFFB, 8'h80);
    ader_rd(1);
    csr_rd(32'h0007FF33);
    access(32'hC11000, 6'h39, 1'b0, 8'h00);

    // asynchronous reset while in CSR state
    @(negedge clk);
    acc_valid = 1'b1;
    acc_addr  = 32'h0007FF33;
    acc_am    = 6'h2F;
    acc_we    = 1'b1;
    acc_data  = 8'h55;
    @(posedge clk);
    #2 rst_n = 1'b0;
    m_en = 1'b0;
    model_clear();
    @(negedge clk);
    chk("midrst_ack", 64'(acc_ack_o), 64'd0);
    chk("midrst_outs_a", {acc_rdata_o, dec_valid_o, dec_hit_o,
                          dec_func_o}, 64'd0);
    chk("midrst_offset", 64'(dec_offset_o), 64'd0);
    chk("midrst_outs_b", {module_enable_o, usr_ctrl_o,
                          soft_rst_o}, 64'd0);
    acc_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    csr_rd(32'h0007FF33);
    ader_wr(1, 32'h00C000E4, 4);
    csr_wr(19'h7FFFB, 8'h10);
    access(32'hC11000, 6'h39, 1'b0, 8'h00);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      f = $urandom_range(0, 7);
      if (r < 3) begin
        v = $urandom;
        am = c_ams[$urandom_range(0, 4)];
        v[7:0] = {am, 1'b0, 1'($urandom_range(0, 5) == 0)};
        ader_wr(f, v, ($urandom_range(0, 4) == 0) ? 3 : 4);
      end else if (r == 3) begin
        sel = $urandom_range(0, 5);
        v = $urandom;
        case (sel)
          0: csr_wr(19'h7FFFB, ($urandom_range(0, 19) == 0) ?
                     8'h90 : (v[7:0] & 8'h7F) | 8'h10);
          1: csr_wr(19'h7FFF7, ($urandom_range(0, 3) == 0) ?
                     8'h10 : v[7:0] & 8'hEF);
          2: csr_wr(19'h7FF33, v[7:0]);
          3: ader_rd(f);
          4: csr_rd({v[31:19], 12'h7FF, v[6:0]});
          default: csr_rd(32'h0007FF33);
        endcase
      end else begin
        v = $urandom;
        a = ($urandom_range(0, 1) == 1) ?
            ((m_act[f] & 32'hFF000000) | (v & 32'h00FFFFFF)) :
            ((m_act[f] & 32'hFFF80000) | (v & 32'h0007FFFF));
        am = ($urandom_range(0, 9) < 7) ? 6'(m_act[f][7:2]) :
             c_ams[$urandom_range(0, 6)];
        if (am == 6'h2F) am = 6'h39;
        access(a, am, 1'b0, 8'h00);
      end
    end

    repeat (4) @(negedge clk);
    chk("sb_empty", 64'(q.size()), 64'd0);
    chk("soft_rst_count", 64'(soft_seen), 64'(soft_exp));
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
